// File: rtl/video_linedoubler.sv
// video_linedoubler: doubles each VIC-rate input line into two pixel-rate
// output lines. It also expands colour width, applies optional scanline
// darkening and regenerates hsync from the measured input timing.
module video_linedoubler #(
  parameter int CW_IN  = 4,
  parameter int CW_OUT = 6,
  parameter int HW     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [CW_IN-1:0]  r_in,
  input  logic [CW_IN-1:0]  g_in,
  input  logic [CW_IN-1:0]  b_in,
  input  logic              bypass,
  input  logic [1:0]        scanlines,
  output logic              hs_out,
  output logic              vs_out,
  output logic [CW_OUT-1:0] r_out,
  output logic [CW_OUT-1:0] g_out,
  output logic [CW_OUT-1:0] b_out,
  output logic [HW-1:0]     line_len
);

  localparam int PW = 3 * CW_IN;
  localparam logic [HW-1:0] WP_MAX = '1;

  typedef enum logic [1:0] {IDLE, LINE0, LINE1} state_t;

  function automatic logic [CW_OUT-1:0] expand(input logic [CW_IN-1:0] x);
    logic [CW_OUT-1:0] w;
    w = CW_OUT'(x);
    return (w << (CW_OUT - CW_IN)) | (w >> (2 * CW_IN - CW_OUT));
  endfunction

  function automatic logic [CW_OUT-1:0] darken(input logic [CW_OUT-1:0] x,
                                               input logic [1:0] sel);
    case (sel)
      2'b01:   return x - (x >> 2);
      2'b10:   return x >> 1;
      2'b11:   return x >> 2;
      default: return x;
    endcase
  endfunction

  logic          hs_prev, wb, valid, seen_one, vs_d;
  logic [HW-1:0] wp, hs_cnt, hsw, rp;
  logic [PW-1:0] mem [0:(2**(HW+1))-1];
  logic [PW-1:0] rdata;
  state_t        state;
  logic          act_d1, l1_d1, hs_d1, vs_d1;

  // The pixel that carries the hs rise is pixel 0 of the new line, so it goes
  // to address 0 of the freshly swapped bank.
  logic          hs_rise, start;
  logic          wb_eff;
  logic [HW-1:0] wp_eff;
  assign hs_rise = ce_in & hs_in & ~hs_prev;
  assign wb_eff  = hs_rise ? ~wb : wb;
  assign wp_eff  = hs_rise ? '0 : wp;
  assign start   = hs_rise & seen_one & (wp != '0);

  // Input measurement: pixel position, line length, hsync width, bank swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      wp       <= '0;
      wb       <= 1'b0;
      hs_cnt   <= '0;
      hsw      <= '0;
      vs_d     <= 1'b0;
      valid    <= 1'b0;
      seen_one <= 1'b0;
      line_len <= '0;
    end else if (ce_in) begin
      hs_prev <= hs_in;
      if (hs_rise) begin
        line_len <= wp;
        hsw      <= hs_cnt >> 1;
        vs_d     <= vs_in;
        wb       <= ~wb;
        valid    <= seen_one;
        seen_one <= 1'b1;
        hs_cnt   <= HW'(1);
      end else if (hs_in && hs_cnt != WP_MAX) begin
        hs_cnt <= hs_cnt + 1'b1;
      end
      wp <= (wp_eff != WP_MAX) ? wp_eff + 1'b1 : wp_eff;
    end
  end

  // Two-bank line buffer: write the current line, read the previous one.
  always_ff @(posedge clk) begin
    if (ce_in && wp_eff != WP_MAX)
      mem[{wb_eff, wp_eff}] <= {r_in, g_in, b_in};
    rdata <= mem[{~wb, rp}];
  end

  // Output sequencer: replays the stored line twice; stage-1 flags align with the RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rp     <= '0;
      act_d1 <= 1'b0;
      l1_d1  <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
    end else begin
      act_d1 <= (state != IDLE) && valid;
      l1_d1  <= (state == LINE1);
      hs_d1  <= (state != IDLE) && valid && (rp < hsw);
      vs_d1  <= vs_d;
      if (start) begin
        state <= LINE0;
        rp    <= '0;
      end else begin
        case (state)
          LINE0: begin
            if (rp == line_len - 1'b1) begin
              state <= LINE1;
              rp    <= '0;
            end else begin
              rp <= rp + 1'b1;
            end
          end
          LINE1: begin
            if (rp == line_len - 1'b1) begin
              state <= IDLE;
              rp    <= '0;
            end else begin
              rp <= rp + 1'b1;
            end
          end
          default: rp <= '0;
        endcase
      end
    end
  end

  // Output register: bypass path or expanded/darkened doubled path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else if (bypass) begin
      hs_out <= hs_in;
      vs_out <= vs_in;
      r_out  <= expand(r_in);
      g_out  <= expand(g_in);
      b_out  <= expand(b_in);
    end else begin
      hs_out <= hs_d1;
      vs_out <= vs_d1;
      if (act_d1) begin
        r_out <= darken(expand(rdata[PW-1 -: CW_IN]), l1_d1 ? scanlines : 2'b00);
        g_out <= darken(expand(rdata[2*CW_IN-1 -: CW_IN]), l1_d1 ? scanlines : 2'b00);
        b_out <= darken(expand(rdata[CW_IN-1 -: CW_IN]), l1_d1 ? scanlines : 2'b00);
      end else begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_video_linedoubler.sv
// Bench for video_linedoubler: directed line sequences with random colours,
// checked every clk against a line-level reference model.
module tb_video_linedoubler;

  logic        clk = 1'b0;
  logic        reset, ce_in, hs_in, vs_in, bypass;
  logic [3:0]  r_in, g_in, b_in;
  logic [1:0]  scanlines;
  logic        hs_out, vs_out;
  logic [5:0]  r_out, g_out, b_out;
  logic [10:0] line_len;

  video_linedoubler dut (
    .clk(clk), .reset(reset), .ce_in(ce_in), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .bypass(bypass), .scanlines(scanlines),
    .hs_out(hs_out), .vs_out(vs_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .line_len(line_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {logic [11:0] pix; logic hs; logic l1;} ent_t;
  typedef struct packed {logic act; logic [11:0] pix; logic hs; logic l1; logic vs;} slot_t;

  // reference model state
  logic [11:0] cur_line[$];
  ent_t        plan[$];
  int          cur_hs, m_line_len;
  logic        seen, m_hs_prev, m_vs_d;
  slot_t       d1, d2;
  logic [5:0]  er, eg, eb;
  logic        ehs, evs;

  function automatic logic [5:0] exp6(input logic [3:0] x);
    return {x, x[3:2]};
  endfunction

  function automatic logic [5:0] dark(input logic [5:0] x, input logic [1:0] s);
    int v;
    v = x;
    case (s)
      2'd1: v = v - v / 4;
      2'd2: v = v / 2;
      2'd3: v = v / 4;
      default: v = v;
    endcase
    return 6'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    cur_line.delete();
    plan.delete();
    cur_hs = 0; m_line_len = 0;
    seen = 0; m_hs_prev = 0; m_vs_d = 0;
    d1 = '0; d2 = '0;
    er = 0; eg = 0; eb = 0; ehs = 0; evs = 0;
  endtask

  task automatic model_update();
    slot_t cur, e;
    ent_t  en;
    int    n;
    if (plan.size() > 0) void'(plan.pop_front());
    if (ce_in) begin
      if (hs_in && !m_hs_prev) begin
        n = cur_line.size();
        if (seen && n > 0) begin
          plan.delete();
          for (int k = 0; k < 2 * n; k++) begin
            en.pix = cur_line[k % n];
            en.hs  = ((k % n) < (cur_hs / 2));
            en.l1  = (k >= n);
            plan.push_back(en);
          end
        end
        m_line_len = n;
        m_vs_d = vs_in;
        seen = 1;
        cur_line.delete();
        cur_hs = 0;
      end
      m_hs_prev = hs_in;
      if (hs_in) cur_hs++;
      if (cur_line.size() < 2047) cur_line.push_back({r_in, g_in, b_in});
    end
    if (plan.size() > 0) cur = {1'b1, plan[0].pix, plan[0].hs, plan[0].l1, m_vs_d};
    else                 cur = {1'b0, 12'h000, 1'b0, 1'b0, m_vs_d};
    e = d2; d2 = d1; d1 = cur;
    if (bypass) begin
      er = exp6(r_in); eg = exp6(g_in); eb = exp6(b_in);
      ehs = hs_in; evs = vs_in;
    end else begin
      evs = e.vs;
      ehs = e.act & e.hs;
      er = e.act ? dark(exp6(e.pix[11:8]), e.l1 ? scanlines : 2'b00) : 6'h00;
      eg = e.act ? dark(exp6(e.pix[7:4]),  e.l1 ? scanlines : 2'b00) : 6'h00;
      eb = e.act ? dark(exp6(e.pix[3:0]),  e.l1 ? scanlines : 2'b00) : 6'h00;
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".r_out"},    32'(r_out),    32'(er));
    chk({where, ".g_out"},    32'(g_out),    32'(eg));
    chk({where, ".b_out"},    32'(b_out),    32'(eb));
    chk({where, ".hs_out"},   32'(hs_out),   32'(ehs));
    chk({where, ".vs_out"},   32'(vs_out),   32'(evs));
    chk({where, ".line_len"}, 32'(line_len), 32'(m_line_len));
  endtask

  task automatic tick(input logic ce, input logic hs, input logic vs,
                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    ce_in = ce; hs_in = hs; vs_in = vs; r_in = r; g_in = g; b_in = b;
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    #1;
    check_outputs("clk");
  endtask

  // mode 0: r = pixel index, g/b random; 1: constant c; 2: all random
  task automatic send_line(input int n, input int hw, input int mode,
                           input logic [3:0] c, input logic vs);
    logic [3:0] r, g, b;
    logic hs;
    for (int i = 0; i < n; i++) begin
      hs = (i < hw);
      case (mode)
        0: begin r = 4'(i); g = 4'($urandom); b = 4'($urandom); end
        1: begin r = c; g = c; b = c; end
        default: begin r = 4'($urandom); g = 4'($urandom); b = 4'($urandom); end
      endcase
      tick(1'b1, hs, vs, r, g, b);
      tick(1'b0, hs, vs, r, g, b);
    end
  endtask

  initial begin
    reset = 1'b1; bypass = 1'b0; scanlines = 2'b00;
    ce_in = 0; hs_in = 0; vs_in = 0; r_in = 0; g_in = 0; b_in = 0;
    model_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    #3 reset = 1'b0;

    // index ramp, N=8, hs 2 pixels
    send_line(8, 2, 0, 4'h0, 1'b0);
    send_line(8, 2, 0, 4'h0, 1'b0);
    send_line(8, 2, 0, 4'h0, 1'b1);
    send_line(8, 2, 0, 4'h0, 1'b0);

    // scanline darkening on constant F
    scanlines = 2'b10;
    repeat (3) send_line(8, 2, 1, 4'hF, 1'b0);
    scanlines = 2'b01;
    repeat (2) send_line(8, 2, 1, 4'hF, 1'b0);
    scanlines = 2'b11;
    repeat (2) send_line(8, 2, 1, 4'hF, 1'b0);
    scanlines = 2'b00;

    // saturating line length
    send_line(3000, 4, 2, 4'h0, 1'b0);
    send_line(2100, 4, 2, 4'h0, 1'b0);
    send_line(8, 2, 2, 4'h0, 1'b0);

    // shortened line restarts mid-LINE1
    send_line(8, 2, 0, 4'h0, 1'b0);
    send_line(5, 2, 0, 4'h0, 1'b0);
    send_line(5, 2, 0, 4'h0, 1'b0);
    send_line(8, 2, 0, 4'h0, 1'b0);

    // bypass, then resume doubling
    bypass = 1'b1;
    repeat (2) send_line(6, 2, 1, 4'h8, 1'b1);
    repeat (2) send_line(7, 3, 2, 4'h0, 1'b0);
    bypass = 1'b0;
    repeat (3) send_line(9, 2, 2, 4'h0, 1'b0);

    // random line lengths, sync widths and darkening
    repeat (15) begin
      scanlines = 2'($urandom);
      send_line($urandom_range(4, 20), $urandom_range(1, 3), 2, 4'h0, 1'($urandom));
    end
    scanlines = 2'b00;

    // asynchronous reset during LINE0
    repeat (2) send_line(10, 2, 2, 4'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h5, 4'h6, 4'h7);
    tick(1'b0, 1'b1, 1'b0, 4'h5, 4'h6, 4'h7);
    tick(1'b1, 1'b1, 1'b0, 4'h9, 4'hA, 4'hB);
    tick(1'b0, 1'b1, 1'b0, 4'h9, 4'hA, 4'hB);
    #2 reset = 1'b1;
    model_reset();
    #1 check_outputs("async_reset");
    repeat (3) tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    #3 reset = 1'b0;
    repeat (4) send_line(8, 2, 0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
